// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle functional units beside the ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } mul_state_e;

  // Iteration counter must reach WIDTH itself, hence WIDTH+1 states.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul_core.sv
// Shift-add datapath: one partial product per step on unsigned magnitudes.
module seq_mul_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  input  logic [CNT_W-1:0]   cnt_init,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mult_q;
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      acc_q   <= '0;
      mcand_q <= {{WIDTH{1'b0}}, a_mag};
      mult_q  <= b_mag;
      cnt_q   <= cnt_init;
    end else if (step) begin
      if (mult_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q <= mcand_q << 1;
      mult_q  <= mult_q >> 1;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign acc  = acc_q;
  // High during the step that performs the final iteration.
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_mul_unit.sv
// Sequential multiplier unit: handshake FSM, sign handling and ALU-style flags.
module seq_mul_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P,
  output logic [WIDTH-1:0]   O,
  output logic               OF_UND,
  output logic               ZERO,
  output logic               ERR
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  // -2^(W-1) maps to 2^(W-1), which still fits the unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic overflow(input logic [PW-1:0] p, input logic is_signed);
    logic [WIDTH:0] upper;
    upper = p[PW-1:WIDTH-1];
    if (is_signed) begin
      return !((&upper) || !(|upper));
    end
    return |p[PW-1:WIDTH];
  endfunction

  mul_state_e         state_q, state_d;
  logic               load, step, finish;
  logic               sign_q, signed_q;
  logic               is_zero;
  logic [CNT_W-1:0]   cnt_init;
  logic [PW-1:0]      acc;
  logic               last;
  logic [PW-1:0]      p_next;
  logic [PW-1:0]      p_q;
  logic               of_q, zero_q, done_q, err_q;

  assign is_zero = EARLY_ZERO && ((A == '0) || (B == '0));
  // A zero operand starts on the final iteration, so CALC lasts one cycle.
  assign cnt_init = is_zero ? CNT_W'(WIDTH - 1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  seq_mul_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .a_mag    (magnitude(A, signed_op)),
    .b_mag    (magnitude(B, signed_op)),
    .cnt_init (cnt_init),
    .acc      (acc),
    .last     (last)
  );

  assign p_next = sign_q ? -acc : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      signed_q <= 1'b0;
      p_q      <= '0;
      of_q     <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= finish;
      err_q  <= start && busy;
      if (load) begin
        sign_q   <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
        signed_q <= signed_op;
      end
      // Results hold until the next completion, not cleared on accept.
      if (finish) begin
        p_q    <= p_next;
        of_q   <= overflow(p_next, signed_q);
        zero_q <= (p_next == '0);
      end
    end
  end

  assign done   = done_q;
  assign ERR    = err_q;
  assign P      = p_q;
  assign O      = p_q[WIDTH-1:0];
  assign OF_UND = of_q;
  assign ZERO   = zero_q;

endmodule
